pcie_tx: RTL and testbench

- Transmit-side TLP builder for the 64-bit AXI-stream TX interface of the PCIe hard core; counterpart of the receive path.
- Builds three TLP types from simple request ports: 2-DW read completions (CplD) answering host 32-bit reads, 2-DW 32-bit memory writes (MWr32) and 32-bit memory read requests (MRd32).
- Arbitrates between the three sources and byte-swaps payload DWs so user data is little-endian on both sides.

---
 rtl/pcie_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_pcie_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx.sv
// Transmit-side TLP builder for the 64-bit AXI-stream TX interface of the PCIe core.
// Builds 2-DW CplD, 2-DW MWr32 and MRd32 TLPs from three request ports, arbitrates
// cpl > rd > wr, and byte-swaps payload DWs so user data stays little-endian.
module pcie_tx #(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [15:0] completer_id_i,
  // Completion request
  input  logic        cpl_valid_i,
  output logic        cpl_ack_o,
  input  logic [23:0] cpl_rid_tag_i,
  input  logic [12:0] cpl_addr_i,
  input  logic [63:0] cpl_data_i,
  // Memory write request
  input  logic        wr_valid_i,
  output logic        wr_ack_o,
  input  logic [28:0] wr_addr_i,
  input  logic [63:0] wr_data_i,
  // Memory read request
  input  logic        rd_valid_i,
  output logic        rd_ack_o,
  input  logic [28:0] rd_addr_i,
  input  logic [9:0]  rd_len_i,
  input  logic [7:0]  rd_tag_i,
  // AXI-stream to core
  output logic        tvalid_o,
  input  logic        tready_i,
  output logic        tlast_o,
  output logic [7:0]  tkeep_o,
  output logic [63:0] tdata_o
);

  localparam logic [31:0] CplDw0 = 32'h4A00_0002;  // CplD, 3DW header with data, length 2
  localparam logic [31:0] MwrDw0 = 32'h4000_0002;  // MWr32, 3DW header with data, length 2

  typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} state_e;

  state_e      state_q, state_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic [63:0] tdata_q, tdata_d;
  // Beats 1 and 2 are built at capture time so the request ports are free right after ack.
  logic [63:0] beat1_q, beat1_d;
  logic [63:0] beat2_q, beat2_d;
  // Set for MRd: two-beat TLP, beat 1 is the final, half-filled beat.
  logic        short_q, short_d;
  logic        cpl_ack_q, cpl_ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic        wr_ack_q, wr_ack_d;

  function automatic logic [31:0] swap_dw(input logic [31:0] x);
    if (SWAP_BYTES) begin
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
    end
    return x;
  endfunction

  // ---------------------------------------------------------------------------
  // Header and payload DWs for each source
  // ---------------------------------------------------------------------------
  logic [31:0] cpl_dw1, cpl_dw2, cpl_p0, cpl_p1;
  logic [31:0] wr_dw1, wr_dw2, wr_p0, wr_p1;
  logic [31:0] rd_dw0, rd_dw1, rd_dw2;
  logic [7:0]  rd_be;

  // Only the low nibble of the qword address feeds the lower-address field.
  logic unused_cpl_addr;
  assign unused_cpl_addr = ^cpl_addr_i[12:4];

  // Completion: status SC, byte count 8, lower address from the qword address.
  assign cpl_dw1 = {completer_id_i, 16'h0008};
  assign cpl_dw2 = {cpl_rid_tag_i, 1'b0, cpl_addr_i[3:0], 3'b000};
  assign cpl_p0  = swap_dw(cpl_data_i[31:0]);
  assign cpl_p1  = swap_dw(cpl_data_i[63:32]);

  // Memory write: tag 0, both byte enables full.
  assign wr_dw1 = {completer_id_i, 8'h00, 8'hFF};
  assign wr_dw2 = {wr_addr_i, 3'b000};
  assign wr_p0  = swap_dw(wr_data_i[31:0]);
  assign wr_p1  = swap_dw(wr_data_i[63:32]);

  // Memory read: single-DW reads must leave last BE zero.
  assign rd_be  = (rd_len_i == 10'd1) ? 8'h0F : 8'hFF;
  assign rd_dw0 = {22'h0, rd_len_i};
  assign rd_dw1 = {completer_id_i, rd_tag_i, rd_be};
  assign rd_dw2 = {rd_addr_i, 3'b000};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, capture and beat sequencing
  always_comb begin
    state_d   = state_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tkeep_d   = tkeep_q;
    tdata_d   = tdata_q;
    beat1_d   = beat1_q;
    beat2_d   = beat2_q;
    short_d   = short_q;
    cpl_ack_d = 1'b0;
    rd_ack_d  = 1'b0;
    wr_ack_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cpl_valid_i) begin
          cpl_ack_d = 1'b1;
          tdata_d   = {cpl_dw1, CplDw0};
          beat1_d   = {cpl_p0, cpl_dw2};
          beat2_d   = {32'h0, cpl_p1};
          short_d   = 1'b0;
        end else if (rd_valid_i) begin
          rd_ack_d  = 1'b1;
          tdata_d   = {rd_dw1, rd_dw0};
          beat1_d   = {32'h0, rd_dw2};
          beat2_d   = 64'h0;
          short_d   = 1'b1;
        end else if (wr_valid_i) begin
          wr_ack_d  = 1'b1;
          tdata_d   = {wr_dw1, MwrDw0};
          beat1_d   = {wr_p0, wr_dw2};
          beat2_d   = {32'h0, wr_p1};
          short_d   = 1'b0;
        end
        if (cpl_valid_i || rd_valid_i || wr_valid_i) begin
          tvalid_d = 1'b1;
          tkeep_d  = 8'hFF;
          tlast_d  = 1'b0;
          state_d  = StB0;
        end
      end

      StB0: begin
        if (tready_i) begin
          tdata_d = beat1_q;
          tkeep_d = short_q ? 8'h0F : 8'hFF;
          tlast_d = short_q;
          state_d = StB1;
        end
      end

      StB1: begin
        if (tready_i) begin
          if (short_q) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tkeep_d  = 8'h00;
            tdata_d  = 64'h0;
            state_d  = StIdle;
          end else begin
            tdata_d = beat2_q;
            tkeep_d = 8'h0F;
            tlast_d = 1'b1;
            state_d = StB2;
          end
        end
      end

      StB2: begin
        if (tready_i) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tkeep_d  = 8'h00;
          tdata_d  = 64'h0;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------

  // Output beat, staged beats and ack pulses
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tkeep_q   <= 8'h00;
      tdata_q   <= 64'h0;
      beat1_q   <= 64'h0;
      beat2_q   <= 64'h0;
      short_q   <= 1'b0;
      cpl_ack_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
    end else begin
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tkeep_q   <= tkeep_d;
      tdata_q   <= tdata_d;
      beat1_q   <= beat1_d;
      beat2_q   <= beat2_d;
      short_q   <= short_d;
      cpl_ack_q <= cpl_ack_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
    end
  end

  assign tvalid_o  = tvalid_q;
  assign tlast_o   = tlast_q;
  assign tkeep_o   = tkeep_q;
  assign tdata_o   = tdata_q;
  assign cpl_ack_o = cpl_ack_q;
  assign rd_ack_o  = rd_ack_q;
  assign wr_ack_o  = wr_ack_q;

endmodule

// File: tb/tb_pcie_tx.sv
// Scoreboard bench for pcie_tx: one instance with byte swap, one without, sharing stimulus.
module tb_pcie_tx;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] completer_id = '0;
  logic        cpl_valid = 1'b0;
  logic [23:0] cpl_rid_tag = '0;
  logic [12:0] cpl_addr = '0;
  logic [63:0] cpl_data = '0;
  logic        wr_valid = 1'b0;
  logic [28:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic [28:0] rd_addr = '0;
  logic [9:0]  rd_len = '0;
  logic [7:0]  rd_tag = '0;
  logic        tready = 1'b1;

  logic        cpl_ack_a, wr_ack_a, rd_ack_a, tvalid_a, tlast_a;
  logic [7:0]  tkeep_a;
  logic [63:0] tdata_a;
  logic        cpl_ack_b, wr_ack_b, rd_ack_b, tvalid_b, tlast_b;
  logic [7:0]  tkeep_b;
  logic [63:0] tdata_b;

  int n_cmp = 0;
  int n_err = 0;
  int mode = 0;  // tready: 0 always high, 1 random, 2 fixed pattern
  int pidx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  beat_t qa[$];
  beat_t qb[$];
  logic        pv[2], pr[2], pl[2];
  logic [7:0]  pk[2];
  logic [63:0] pd[2];
  logic [2:0]  prev_valid = 3'b000;  // {cpl, rd, wr} at the previous sample

  pcie_tx #(.SWAP_BYTES(1'b1)) u_dut_a (
    .clock_i(clk), .reset_i(rst), .completer_id_i(completer_id),
    .cpl_valid_i(cpl_valid), .cpl_ack_o(cpl_ack_a), .cpl_rid_tag_i(cpl_rid_tag),
    .cpl_addr_i(cpl_addr), .cpl_data_i(cpl_data),
    .wr_valid_i(wr_valid), .wr_ack_o(wr_ack_a), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ack_o(rd_ack_a), .rd_addr_i(rd_addr), .rd_len_i(rd_len),
    .rd_tag_i(rd_tag),
    .tvalid_o(tvalid_a), .tready_i(tready), .tlast_o(tlast_a), .tkeep_o(tkeep_a),
    .tdata_o(tdata_a)
  );

  pcie_tx #(.SWAP_BYTES(1'b0)) u_dut_b (
    .clock_i(clk), .reset_i(rst), .completer_id_i(completer_id),
    .cpl_valid_i(cpl_valid), .cpl_ack_o(cpl_ack_b), .cpl_rid_tag_i(cpl_rid_tag),
    .cpl_addr_i(cpl_addr), .cpl_data_i(cpl_data),
    .wr_valid_i(wr_valid), .wr_ack_o(wr_ack_b), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_valid_i(rd_valid), .rd_ack_o(rd_ack_b), .rd_addr_i(rd_addr), .rd_len_i(rd_len),
    .rd_tag_i(rd_tag),
    .tvalid_o(tvalid_b), .tready_i(tready), .tlast_o(tlast_b), .tkeep_o(tkeep_b),
    .tdata_o(tdata_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x, input bit en);
    return en ? {x[7:0], x[15:8], x[23:16], x[31:24]} : x;
  endfunction

  // Reference model: list the TLP's DWs in wire order, then pack two per beat.
  function automatic void push_tlp(input int kind, input bit sw);
    logic [31:0] dw[$];
    beat_t b;
    case (kind)
      0: begin
        dw.push_back(32'h4A00_0002);
        dw.push_back({completer_id, 16'h0008});
        dw.push_back({cpl_rid_tag, 1'b0, cpl_addr[3:0], 3'b000});
        dw.push_back(bswap(cpl_data[31:0], sw));
        dw.push_back(bswap(cpl_data[63:32], sw));
      end
      1: begin
        dw.push_back({22'h0, rd_len});
        dw.push_back({completer_id, rd_tag, (rd_len == 10'd1) ? 8'h0F : 8'hFF});
        dw.push_back({rd_addr, 3'b000});
      end
      default: begin
        dw.push_back(32'h4000_0002);
        dw.push_back({completer_id, 8'h00, 8'hFF});
        dw.push_back({wr_addr, 3'b000});
        dw.push_back(bswap(wr_data[31:0], sw));
        dw.push_back(bswap(wr_data[63:32], sw));
      end
    endcase
    for (int i = 0; i < dw.size(); i += 2) begin
      if (i + 1 < dw.size()) begin
        b.d = {dw[i+1], dw[i]};
        b.k = 8'hFF;
      end else begin
        b.d = {32'h0, dw[i]};
        b.k = 8'h0F;
      end
      b.l = (i + 2 >= dw.size());
      if (sw) qa.push_back(b);
      else qb.push_back(b);
    end
  endfunction

  task automatic ack_check(input int w, input logic c, input logic r, input logic wa);
    string p = (w == 0) ? "a " : "b ";
    if (c || r || wa) begin
      chk($countones({c, r, wa}) == 1, {p, "ack_onehot"}, 64'({c, r, wa}), 64'd1);
      if (c) chk(prev_valid[2], {p, "cpl_ack_no_valid"}, 64'(prev_valid), 64'h4);
      if (r) chk(prev_valid[2:1] == 2'b01, {p, "rd_ack_priority"}, 64'(prev_valid), 64'h2);
      if (wa) chk(prev_valid == 3'b001, {p, "wr_ack_priority"}, 64'(prev_valid), 64'h1);
      if (w == 0) begin
        if (c) begin push_tlp(0, 1'b1); push_tlp(0, 1'b0); end
        if (r) begin push_tlp(1, 1'b1); push_tlp(1, 1'b0); end
        if (wa) begin push_tlp(2, 1'b1); push_tlp(2, 1'b0); end
      end
    end
  endtask

  task automatic mon_step(input int w, input logic tv, input logic tl, input logic [7:0] tk,
                          input logic [63:0] td);
    beat_t e;
    string p = (w == 0) ? "a " : "b ";
    if (pv[w] && !pr[w]) begin
      chk(tv && tl == pl[w] && tk == pk[w] && td == pd[w], {p, "hold_while_stalled"}, td, pd[w]);
    end
    if (pv[w] && pr[w] && pl[w]) chk(!tv, {p, "idle_gap"}, 64'(tv), 64'd0);
    if (tv && tready) begin
      if ((w == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
        chk(1'b0, {p, "unexpected_beat"}, td, 64'd0);
      end else begin
        if (w == 0) e = qa.pop_front();
        else e = qb.pop_front();
        chk(td == e.d, {p, "tdata"}, td, e.d);
        chk(tk == e.k, {p, "tkeep"}, 64'(tk), 64'(e.k));
        chk(tl == e.l, {p, "tlast"}, 64'(tl), 64'(e.l));
      end
    end
    pv[w] = tv; pr[w] = tready; pl[w] = tl; pk[w] = tk; pd[w] = td;
  endtask

  // Monitor: mid-cycle sampling of acks and beats
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
      end else begin
        ack_check(0, cpl_ack_a, rd_ack_a, wr_ack_a);
        ack_check(1, cpl_ack_b, rd_ack_b, wr_ack_b);
        mon_step(0, tvalid_a, tlast_a, tkeep_a, tdata_a);
        mon_step(1, tvalid_b, tlast_b, tkeep_b, tdata_b);
      end
      prev_valid = {cpl_valid, rd_valid, wr_valid};
    end
  end

  // tready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: tready = 1'b1;
        1: tready = ($urandom_range(0, 3) != 0);
        default: begin
          tready = pat[pidx % 6];
          pidx++;
        end
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Raise one source's valid and wait (bounded) for its ack, then drop valid.
  task automatic send(input int kind);
    logic got = 1'b0;
    case (kind)
      0: cpl_valid = 1'b1;
      1: rd_valid = 1'b1;
      default: wr_valid = 1'b1;
    endcase
    for (int i = 0; i < 400 && !got; i++) begin
      @(posedge clk);
      #1;
      got = (kind == 0) ? cpl_ack_a : (kind == 1) ? rd_ack_a : wr_ack_a;
    end
    case (kind)
      0: cpl_valid = 1'b0;
      1: rd_valid = 1'b0;
      default: wr_valid = 1'b0;
    endcase
    chk(got, "ack_timeout", 64'(got), 64'd1);
  endtask

  task automatic rand_src(input int kind, input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
      case (kind)
        0: begin
          cpl_rid_tag = 24'($urandom);
          cpl_addr    = 13'($urandom);
          cpl_data    = {$urandom, $urandom};
        end
        1: begin
          rd_addr = 29'($urandom);
          rd_len  = ($urandom_range(0, 3) == 0) ? 10'd1 : 10'($urandom);
          rd_tag  = 8'($urandom);
        end
        default: begin
          wr_addr = 29'($urandom);
          wr_data = {$urandom, $urandom};
        end
      endcase
      send(kind);
    end
  endtask

  task automatic drain();
    logic done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (qa.size() == 0) && (qb.size() == 0) && !tvalid_a && !tvalid_b;
    end
    chk(done, "drain_timeout", 64'(qa.size()), 64'd0);
  endtask

  task automatic rst_check(input string name);
    chk({tvalid_a, tlast_a, cpl_ack_a, rd_ack_a, wr_ack_a} == 5'b0, {name, " a ctrl"},
        64'({tvalid_a, tlast_a, cpl_ack_a, rd_ack_a, wr_ack_a}), 64'd0);
    chk(tkeep_a == 8'h0 && tdata_a == 64'h0, {name, " a data"}, tdata_a, 64'd0);
    chk({tvalid_b, tlast_b, cpl_ack_b, rd_ack_b, wr_ack_b} == 5'b0, {name, " b ctrl"},
        64'({tvalid_b, tlast_b, cpl_ack_b, rd_ack_b, wr_ack_b}), 64'd0);
    chk(tkeep_b == 8'h0 && tdata_b == 64'h0, {name, " b data"}, tdata_b, 64'd0);
  endtask

  initial begin
    logic got;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_check("reset_values");
    #2 rst = 1'b0;
    completer_id = 16'h0100;

    // Completion example
    @(posedge clk); #1;
    cpl_rid_tag = 24'h00AB12; cpl_addr = 13'h0013; cpl_data = 64'h8877665544332211;
    send(0);
    drain();

    // Memory reads: rd_len 16 then rd_len 1
    @(posedge clk); #1;
    rd_addr = 29'h0200_0008; rd_len = 10'd16; rd_tag = 8'h05;
    send(1);
    drain();
    @(posedge clk); #1;
    rd_len = 10'd1;
    send(1);
    drain();

    // Memory write with stalling tready
    mode = 2;
    @(posedge clk); #1;
    wr_addr = 29'h0000_0401; wr_data = 64'h0000000200000001;
    send(2);
    drain();
    mode = 0;

    // All three sources at once
    @(posedge clk); #1;
    cpl_rid_tag = 24'h123456; cpl_addr = 13'h1FFF; cpl_data = 64'hDEADBEEF_CAFEF00D;
    rd_addr = 29'h1FFF_FFFF; rd_len = 10'd0; rd_tag = 8'hFF;
    wr_addr = 29'h0ABC_DEF0; wr_data = 64'h0123456789ABCDEF;
    fork
      send(0);
      send(1);
      send(2);
    join
    drain();

    // Randomized concurrent traffic
    mode = 1;
    completer_id = 16'($urandom);
    fork
      rand_src(0, 25);
      rand_src(1, 25);
      rand_src(2, 25);
    join
    drain();

    // Reset in the middle of a TLP with a write pending
    mode = 0;
    @(posedge clk); #1;
    cpl_rid_tag = 24'h00AB12; cpl_addr = 13'h0013; cpl_data = 64'h8877665544332211;
    wr_addr = 29'h0000_0401; wr_data = 64'h0000000200000001;
    cpl_valid = 1'b1;
    wr_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = cpl_ack_a;
    end
    cpl_valid = 1'b0;
    chk(got, "reset_test cpl_ack", 64'(got), 64'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    rst_check("async_reset");
    qa.delete();
    qb.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      got = wr_ack_a;
    end
    wr_valid = 1'b0;
    chk(got, "post_reset wr_ack", 64'(got), 64'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
